// File: rtl/i2c_mm_pkg.sv
// Shared types and constants for the multi-master I2C bus monitor.
// Holds the monitor state enum, default parameter values and a counter width helper.
package i2c_mm_pkg;

    typedef enum logic [1:0] {
        StBuf   = 2'd0,
        StFree  = 2'd1,
        StBusy  = 2'd2,
        StOwned = 2'd3
    } mm_state_e;

    localparam int unsigned DefFilterLen    = 3;
    localparam int unsigned DefBufCycles    = 50;
    localparam int unsigned DefTimeoutCycles = 100000;

    // One spare bit so a counter can hold its limit value without wrapping.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser plus N-equal-sample glitch filter for one open-drain line.
// valid_o rises once the pipeline has been refilled with real samples after reset.
module i2c_glitch_filter
    import i2c_mm_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DefFilterLen
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic filt_o,
    output logic valid_o
);

    localparam int unsigned CntW      = cnt_width(FILTER_LEN);
    localparam int unsigned SettleLen = FILTER_LEN + 2;
    localparam int unsigned SettleW   = cnt_width(SettleLen);

    logic                sync1_q, sync2_q;
    logic                filt_q, filt_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [SettleW-1:0]  settle_q, settle_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        // cnt_q counts consecutive samples that disagree with the filtered value.
        if (sync2_q != filt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        settle_d = settle_q;
        if (settle_q != SettleW'(SettleLen)) begin
            settle_d = settle_q + SettleW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            filt_q   <= 1'b1;
            cnt_q    <= '0;
            settle_q <= '0;
        end else begin
            sync1_q  <= line_i;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
        end
    end

    assign filt_o  = filt_q;
    assign valid_o = (settle_q == SettleW'(SettleLen));

endmodule

// File: rtl/i2c_mm_monitor.sv
// Multi-master I2C bus monitor and access gate: filters SCL/SDA, tracks bus ownership,
// grants the local master, and flags START/STOP, arbitration loss and SCL-stuck timeouts.
module i2c_mm_monitor
    import i2c_mm_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = DefFilterLen,
    parameter int unsigned BUF_CYCLES     = DefBufCycles,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic SCL,
    input  logic SDA,
    input  logic SDA_drv,
    input  logic req,
    output logic gnt,
    output logic I2C_Busy,
    output logic I2C_Free,
    output logic start_det,
    output logic stop_det,
    output logic arb_lost,
    output logic bus_timeout
);

    localparam int unsigned BufW = cnt_width(BUF_CYCLES);
    localparam int unsigned ToW  = cnt_width(TIMEOUT_CYCLES);

    logic scl_f, sda_f, scl_v, sda_v;
    logic scl_p_q, sda_p_q;

    mm_state_e       state_q, state_d;
    logic [BufW-1:0] buf_cnt_q, buf_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d, to_inc;
    logic            own_q, own_d;
    logic            gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            start_q, start_d;
    logic            stop_q, stop_d;
    logic            arb_q, arb_d;
    logic            to_q, to_d;
    logic            start_c, stop_c, rise_c, lines_idle, to_hit;

    i2c_glitch_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_scl_filt (
        .clk    (clk),
        .rst    (rst),
        .line_i (SCL),
        .filt_o (scl_f),
        .valid_o(scl_v)
    );

    i2c_glitch_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sda_filt (
        .clk    (clk),
        .rst    (rst),
        .line_i (SDA),
        .filt_o (sda_f),
        .valid_o(sda_v)
    );

    always_comb begin
        start_c    = scl_f & sda_p_q & ~sda_f;
        stop_c     = scl_f & ~sda_p_q & sda_f;
        rise_c     = scl_f & ~scl_p_q;
        // Idle time only counts once both filters hold genuine post-reset samples.
        lines_idle = scl_f & sda_f & scl_v & sda_v;

        state_d = state_q;
        arb_d   = 1'b0;
        to_d    = 1'b0;

        to_inc = '0;
        if ((state_q == StBusy || state_q == StOwned) && !scl_f) begin
            to_inc = (to_cnt_q == ToW'(TIMEOUT_CYCLES)) ? to_cnt_q : to_cnt_q + ToW'(1);
        end
        to_hit = (to_inc == ToW'(TIMEOUT_CYCLES));

        buf_cnt_d = '0;
        if (state_q == StBuf && lines_idle) begin
            buf_cnt_d = (buf_cnt_q == BufW'(BUF_CYCLES)) ? buf_cnt_q : buf_cnt_q + BufW'(1);
        end

        if (to_hit) begin
            to_d    = 1'b1;
            state_d = StBuf;
        end else begin
            unique case (state_q)
                StBuf: begin
                    if (start_c) begin
                        state_d = StBusy;
                    end else if (buf_cnt_d == BufW'(BUF_CYCLES)) begin
                        state_d = StFree;
                    end
                end
                StFree: begin
                    // A foreign START beats a same-cycle local request.
                    if (start_c) begin
                        state_d = StBusy;
                    end else if (req) begin
                        state_d = StOwned;
                    end
                end
                StBusy: begin
                    if (stop_c) begin
                        state_d = StBuf;
                    end
                end
                StOwned: begin
                    if (stop_c) begin
                        state_d = StBuf;
                    end else if (rise_c && SDA_drv && !sda_f && own_q) begin
                        arb_d   = 1'b1;
                        state_d = StBusy;
                    end else if (!req) begin
                        state_d = own_q ? StBusy : StFree;
                    end
                end
                default: state_d = StBuf;
            endcase
        end

        to_cnt_d = (state_d != state_q) ? '0 : to_inc;
        own_d    = (state_d == StOwned) & (own_q | start_c);
        start_d  = start_c;
        stop_d   = stop_c;

        if (!enable) begin
            state_d   = StBuf;
            buf_cnt_d = '0;
            to_cnt_d  = '0;
            own_d     = 1'b0;
            start_d   = 1'b0;
            stop_d    = 1'b0;
            arb_d     = 1'b0;
            to_d      = 1'b0;
        end

        gnt_d  = (state_d == StOwned);
        busy_d = (state_d != StFree);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_p_q   <= 1'b1;
            sda_p_q   <= 1'b1;
            state_q   <= StBuf;
            buf_cnt_q <= '0;
            to_cnt_q  <= '0;
            own_q     <= 1'b0;
            gnt_q     <= 1'b0;
            busy_q    <= 1'b1;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            arb_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            scl_p_q   <= scl_f;
            sda_p_q   <= sda_f;
            state_q   <= state_d;
            buf_cnt_q <= buf_cnt_d;
            to_cnt_q  <= to_cnt_d;
            own_q     <= own_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            arb_q     <= arb_d;
            to_q      <= to_d;
        end
    end

    assign gnt         = gnt_q;
    assign I2C_Busy    = busy_q;
    assign I2C_Free    = ~busy_q;
    assign start_det   = start_q;
    assign stop_det    = stop_q;
    assign arb_lost    = arb_q;
    assign bus_timeout = to_q;

endmodule

// File: tb/tb_i2c_mm_monitor.sv
// Directed scenarios plus a random bus phase, checked against a behavioural model.
// Idle-after-reset: I2C_Free is first seen high on the 13th clock after rst release.
module tb_i2c_mm_monitor;

    localparam int unsigned FL = 3;
    localparam int unsigned BC = 8;
    localparam int unsigned TC = 20;
    localparam int H = 8;
    localparam int MBuf = 0, MFree = 1, MBusy = 2, MOwned = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic SCL = 1'b1, SDA = 1'b1, SDA_drv = 1'b1, req = 1'b0;
    logic gnt, I2C_Busy, I2C_Free, start_det, stop_det, arb_lost, bus_timeout;

    i2c_mm_monitor #(
        .FILTER_LEN    (FL),
        .BUF_CYCLES    (BC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .SCL        (SCL),
        .SDA        (SDA),
        .SDA_drv    (SDA_drv),
        .req        (req),
        .gnt        (gnt),
        .I2C_Busy   (I2C_Busy),
        .I2C_Free   (I2C_Free),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .arb_lost   (arb_lost),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Behavioural model: index 0 = SCL, 1 = SDA.
    int m_state, m_buf, m_to, m_edges;
    bit m_own, m_gnt, m_busy, m_start, m_stop, m_arb, m_tout;
    bit m_s1[2], m_s2[2], m_f[2], m_p[2];
    bit m_hist[2][FL];

    task automatic m_reset();
        m_state = MBuf; m_buf = 0; m_to = 0; m_edges = 0; m_own = 0;
        m_gnt = 0; m_busy = 1; m_start = 0; m_stop = 0; m_arb = 0; m_tout = 0;
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 1; m_s2[i] = 1; m_f[i] = 1; m_p[i] = 1;
            for (int k = 0; k < int'(FL); k++) m_hist[i][k] = 1;
        end
    endtask

    task automatic m_step();
        bit st, sp, rs, lh, same;
        bit pins[2];
        int tnew, ns;
        pins[0] = SCL;
        pins[1] = SDA;
        st = m_f[0] && m_p[1] && !m_f[1];
        sp = m_f[0] && !m_p[1] && m_f[1];
        rs = m_f[0] && !m_p[0];
        lh = m_f[0] && m_f[1] && (m_edges >= int'(FL) + 2);
        ns = m_state; m_arb = 0; m_tout = 0;
        tnew = ((m_state == MBusy || m_state == MOwned) && !m_f[0]) ? m_to + 1 : 0;
        if (tnew >= int'(TC)) begin
            m_tout = 1; ns = MBuf;
        end else begin
            case (m_state)
                MBuf:   if (st) ns = MBusy; else if (lh && m_buf + 1 >= int'(BC)) ns = MFree;
                MFree:  if (st) ns = MBusy; else if (req) ns = MOwned;
                MBusy:  if (sp) ns = MBuf;
                default: begin
                    if (sp) ns = MBuf;
                    else if (rs && SDA_drv && !m_f[1] && m_own) begin m_arb = 1; ns = MBusy; end
                    else if (!req) ns = m_own ? MBusy : MFree;
                end
            endcase
        end
        m_buf = (m_state == MBuf && lh) ? m_buf + 1 : 0;
        m_to = (ns != m_state) ? 0 : tnew;
        m_own = (ns == MOwned) && (m_own || st);
        m_start = st; m_stop = sp;
        if (!enable) begin
            ns = MBuf; m_buf = 0; m_to = 0; m_own = 0;
            m_start = 0; m_stop = 0; m_arb = 0; m_tout = 0;
        end
        m_state = ns;
        m_gnt = (ns == MOwned);
        m_busy = (ns != MFree);
        for (int i = 0; i < 2; i++) begin
            m_p[i] = m_f[i];
            for (int k = int'(FL) - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = m_s2[i];
            same = 1;
            for (int k = 1; k < int'(FL); k++) if (m_hist[i][k] != m_hist[i][0]) same = 0;
            if (same) m_f[i] = m_hist[i][0];
            m_s2[i] = m_s1[i];
            m_s1[i] = pins[i];
        end
        m_edges++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step();
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int cyc_n = 0;
    bit seen_start, seen_stop, seen_arb, seen_to, seen_gnt;
    int stop_at, free_rise_at, gnt_rise_at;
    logic free_prev = 1'b0, gnt_prev = 1'b0;

    task automatic clear_seen();
        seen_start = 0; seen_stop = 0; seen_arb = 0; seen_to = 0; seen_gnt = 0;
        stop_at = -1; free_rise_at = -1; gnt_rise_at = -1;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc_n++;
            chk("gnt", gnt, m_gnt);
            chk("busy", I2C_Busy, m_busy);
            chk("free", I2C_Free, !m_busy);
            chk("start_det", start_det, m_start);
            chk("stop_det", stop_det, m_stop);
            chk("arb_lost", arb_lost, m_arb);
            chk("bus_timeout", bus_timeout, m_tout);
            if (start_det) seen_start = 1;
            if (stop_det) begin seen_stop = 1; stop_at = cyc_n; end
            if (arb_lost) seen_arb = 1;
            if (bus_timeout) seen_to = 1;
            if (gnt) seen_gnt = 1;
            if (I2C_Free && !free_prev) free_rise_at = cyc_n;
            if (gnt && !gnt_prev) gnt_rise_at = cyc_n;
            free_prev = I2C_Free;
            gnt_prev = gnt;
        end
    endtask

    task automatic bus_start();
        SDA = 0; cyc(H); SCL = 0; cyc(H);
    endtask

    task automatic bus_bit(input bit b);
        SDA = b; cyc(H); SCL = 1; cyc(H); SCL = 0; cyc(H);
    endtask

    task automatic bus_stop();
        SDA = 0; cyc(H); SCL = 1; cyc(H); SDA = 1; cyc(H);
    endtask

    task automatic wait_gnt(input string tag, input int budget);
        int k = 0;
        while (!gnt && k < budget) begin cyc(1); k++; end
        chk(tag, gnt, 1'b1);
    endtask

    initial begin
        int first_free;
        int scl_run, sda_run;
        clear_seen();

        // Reset values while rst is held.
        #12;
        chk("rst_gnt", gnt, 1'b0);
        chk("rst_busy", I2C_Busy, 1'b1);
        chk("rst_free", I2C_Free, 1'b0);
        chk("rst_start", start_det, 1'b0);
        chk("rst_timeout", bus_timeout, 1'b0);
        @(negedge clk);
        rst = 0;

        // Idle after reset.
        first_free = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (I2C_Free && first_free < 0) first_free = i;
        end
        chk_int("idle_free_clock", first_free, 2 + FL + BC);
        chk("idle_no_pulse", seen_start | seen_stop | seen_arb | seen_to, 1'b0);

        // Glitch rejection.
        clear_seen();
        SDA = 0; cyc(2); SDA = 1; cyc(10);
        chk("glitch_no_start", seen_start, 1'b0);
        chk("glitch_still_free", I2C_Free, 1'b1);

        // Foreign transfer with a pending local request.
        clear_seen();
        bus_start();
        req = 1;
        for (int b = 0; b < 9; b++) bus_bit(1'($urandom_range(0, 1)));
        bus_stop();
        chk("foreign_start", seen_start, 1'b1);
        chk("foreign_stop", seen_stop, 1'b1);
        chk("foreign_no_gnt", seen_gnt, 1'b0);
        cyc(12);
        chk_int("foreign_buf_time", free_rise_at - stop_at, BC);
        chk_int("foreign_gnt_after_free", gnt_rise_at - free_rise_at, 1);
        chk("foreign_gnt", gnt, 1'b1);

        // Arbitration loss after a local START.
        clear_seen();
        SDA_drv = 0;
        bus_start();
        SDA_drv = 1;
        bus_bit(1'b1);
        chk("arb_not_yet", seen_arb, 1'b0);
        SDA = 0; cyc(H); SCL = 1; cyc(H);
        chk("arb_pulse", seen_arb, 1'b1);
        chk("arb_gnt_low", gnt, 1'b0);
        SCL = 0; cyc(H);
        bus_bit(1'b1);
        chk("arb_busy_until_stop", I2C_Busy, 1'b1);
        bus_stop();
        req = 0;
        cyc(20);
        chk("arb_free_after", I2C_Free, 1'b1);

        // SCL stuck low while owned.
        clear_seen();
        req = 1;
        wait_gnt("to_wait_gnt", 10);
        SCL = 0; cyc(25); SCL = 1; cyc(2);
        chk("to_pulse", seen_to, 1'b1);
        chk("to_gnt_low", gnt, 1'b0);
        chk("to_busy", I2C_Busy, 1'b1);
        req = 0;
        cyc(20);
        chk("to_free_after", I2C_Free, 1'b1);

        // req rises on the same clock the foreign START is seen.
        clear_seen();
        SDA = 0; cyc(2 + FL);
        req = 1;
        cyc(1);
        chk("simul_start", start_det, 1'b1);
        chk("simul_gnt", gnt, 1'b0);
        SCL = 0; cyc(H);
        bus_bit(1'b0);
        bus_bit(1'b1);
        bus_stop();
        chk("simul_never_gnt", seen_gnt, 1'b0);
        cyc(20);

        // Async reset while owned drops gnt immediately.
        wait_gnt("rst_wait_gnt", 10);
        #2 rst = 1;
        #1 chk("async_rst_gnt", gnt, 1'b0);
        @(negedge clk);
        rst = 0;
        req = 0;
        cyc(20);

        // Random bus activity against the model.
        scl_run = 0;
        sda_run = 0;
        for (int n = 0; n < 3000; n++) begin
            if (scl_run == 0) begin
                SCL = 1'($urandom_range(0, 1));
                scl_run = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30)
                                                       : $urandom_range(1, 10);
            end else scl_run--;
            if (sda_run == 0) begin
                SDA = 1'($urandom_range(0, 1));
                sda_run = $urandom_range(1, 12);
            end else sda_run--;
            if ($urandom_range(0, 15) == 0) req = ~req;
            if ($urandom_range(0, 7) == 0) SDA_drv = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 299) != 0);
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/i2c_mm_monitor.md
# i2c_mm_monitor

Parametrised multi-master bus monitor and access gate for the Simple I2C family. It sits between the raw SCL/SDA pins and a single-master I2C core with an enable pin, and extends plain busy/free tracking with input filtering and enforced bus-free time (tBUF). It also adds a request/grant handshake for the local master, arbitration-loss detection and an SCL-stuck-low timeout. The local master may start a transfer only while `gnt` is high.

## Interface
- `FILTER_LEN`, 3: consecutive identical synchronised samples required before a filtered line changes (≥1).
- `BUF_CYCLES`, 50: clocks SCL and SDA must both be filtered-high after a stop or reset before the bus is declared free (≥1).
- `TIMEOUT_CYCLES`, 100000: consecutive filtered-SCL-low clocks while busy that declare the bus stuck (≥2).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: low clears state to BUF synchronously and holds it there.
- `SCL` in 1: raw bus SCL.
- `SDA` in 1: raw bus SDA.
- `SDA_drv` in 1: local master's SDA intent; 1 = released/high, 0 = pulling low.
- `req` in 1: local master requests the bus; level, held until done.
- `gnt` out 1: local master owns the bus.
- `I2C_Busy` out 1: bus not available, i.e. state ≠ FREE.
- `I2C_Free` out 1: always ~`I2C_Busy`.
- `start_det` out 1: one-cycle pulse on START or repeated START.
- `stop_det` out 1: one-cycle pulse on STOP.
- `arb_lost` out 1: one-cycle pulse when the local master loses arbitration.
- `bus_timeout` out 1: one-cycle pulse on SCL stuck low.

## Operation
- **Input path.** 2-FF synchroniser per line, then glitch filter.
  - Filtered value (`scl_f`, `sda_f`) resets to 1.
  - Filtered value updates only after `FILTER_LEN` equal consecutive synchronised samples.
- **Conditions.** Evaluated on filtered signals and their 1-cycle delayed copies.
  - START = `scl_f` & `sda_f` falling.
  - STOP = `scl_f` & `sda_f` rising.
  - SCL rise = `scl_f` rising.
- **States:** BUF, FREE, BUSY, OWNED. Reset and `enable`=0 go to BUF.
- **BUF**
  - Counter increments while `scl_f`&`sda_f`; clears otherwise.
  - Reaching `BUF_CYCLES` → FREE.
  - START → BUSY.
- **FREE**
  - START → BUSY.
  - Else `req` → OWNED.
  - START and `req` in the same cycle → BUSY; the other master wins, `gnt` stays 0.
- **OWNED** (`gnt`=1). Flag `own_started` is set on the first START observed.
  - STOP → BUF.
  - SCL rise with `SDA_drv`=1 and `sda_f`=0 and `own_started` → `arb_lost` pulse, → BUSY.
  - `req` falls: → BUSY if `own_started`, else → FREE.
- **BUSY**
  - STOP → BUF.
  - START (repeated) → stay, with `start_det` pulse.
- **Timeout.** In BUSY or OWNED, `scl_f` low for `TIMEOUT_CYCLES` consecutive clocks → `bus_timeout` pulse, → BUF.
  - The timeout counter clears on any `scl_f` high and on every state entry.
- **Priority in one cycle:** timeout > STOP > arbitration loss > `req` change.
- Counter widths: `$clog2` of each limit plus 1. Counters saturate and never wrap.

## Timing
- All outputs are registered.
- Reset values: `gnt`=0, `I2C_Busy`=1, `I2C_Free`=0, all pulses 0.
- Pin-to-filtered latency: 2 + `FILTER_LEN` clocks.
- Condition pulses and state change appear 1 clock after the filtered edge.
- `gnt` rises 1 clock after `req` is sampled high in FREE.
- `gnt` falls in the same cycle the state leaves OWNED.
- After reset with an idle bus, `I2C_Free` rises at clock 2 + `FILTER_LEN` + `BUF_CYCLES` (±1, fixed by implementation and documented in the testbench).
- Async `rst` mid-transfer drops `gnt` immediately. The local core must abort.

## Structure
- Package `i2c_mm_pkg` holds:
  - the state enum (BUF/FREE/BUSY/OWNED);
  - default parameter constants;
  - a width helper function.
- Sub-module `i2c_glitch_filter` contains the synchroniser, equal-sample counter and filtered output. It is instantiated twice, for SCL and SDA.
- The FSM, condition detection and counters stay in `i2c_mm_monitor`.

## Test plan
Test parameters: `FILTER_LEN`=3, `BUF_CYCLES`=8, `TIMEOUT_CYCLES`=20.
- **Idle after reset:** release `rst`, lines high → `I2C_Free`=1 after 13±1 clocks; no pulses.
- **Glitch rejection:** 2-clock SDA low pulse with SCL high → no `start_det`; state unchanged.
- **Foreign transfer:** START, bytes, STOP from another master while `req`=1 → `start_det`, `gnt` stays 0, `stop_det`, then `I2C_Free` after 8 high clocks, then `gnt`=1.
- **Arbitration:** in OWNED after local START, `SDA_drv`=1 while SDA forced 0 at SCL rise → `arb_lost` pulse, `gnt`=0, `I2C_Busy`=1 until STOP.
- **Timeout:** in OWNED, hold SCL low 25 clocks → `bus_timeout` pulse, `gnt`=0, state BUF.
- **Simultaneous:** `req` rises in the same cycle as a foreign START in FREE → `gnt` never asserts; `start_det`=1.
